// File: rtl/pipe_flush_ctrl.sv
// Commit-stage recovery sequencer: arbitrates exception/ERET/interrupt/MTC0 in IDLE,
// holds a pipeline-wide flush for FLUSH_CYCLES cycles, then presents a redirect PC to fetch.
module pipe_flush_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter logic [31:0] EXC_VECTOR   = 32'hBFC00380
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        exception_valid,
    input  logic [31:0] exc_target,
    input  logic        eret,
    input  logic [31:0] eret_target,
    input  logic        mtc0,
    input  logic [31:0] mtc0_next_pc,
    input  logic        int_pending,
    input  logic        commit_valid,
    input  logic [31:0] commit_pc,
    input  logic        redirect_ready,
    output logic        flush,
    output logic        stall_fetch,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        int_take,
    output logic [31:0] int_epc,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FLUSH,
        S_REDIRECT
    } state_t;

    localparam logic [3:0] LP_CNT_INIT = 4'(FLUSH_CYCLES - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_nxt;
    logic [31:0] r_tgt;
    logic [31:0] w_tgt_nxt;
    logic        r_int_take;
    logic        w_int_take_nxt;
    logic [31:0] r_int_epc;
    logic [31:0] w_int_epc_nxt;
    logic        w_int_accept;

    // An interrupt needs a committing instruction to supply the EPC; otherwise it waits.
    assign w_int_accept = int_pending && commit_valid;

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_tgt_nxt      = r_tgt;
        w_int_take_nxt = 1'b0;
        w_int_epc_nxt  = r_int_epc;
        case (r_state)
            S_IDLE: begin
                if (exception_valid) begin
                    w_tgt_nxt   = exc_target;
                    w_state_nxt = S_FLUSH;
                    w_cnt_nxt   = LP_CNT_INIT;
                end else if (eret) begin
                    w_tgt_nxt   = eret_target;
                    w_state_nxt = S_FLUSH;
                    w_cnt_nxt   = LP_CNT_INIT;
                end else if (w_int_accept) begin
                    w_tgt_nxt      = EXC_VECTOR;
                    w_int_take_nxt = 1'b1;
                    w_int_epc_nxt  = commit_pc;
                    w_state_nxt    = S_FLUSH;
                    w_cnt_nxt      = LP_CNT_INIT;
                end else if (mtc0) begin
                    w_tgt_nxt   = mtc0_next_pc;
                    w_state_nxt = S_FLUSH;
                    w_cnt_nxt   = LP_CNT_INIT;
                end
            end
            S_FLUSH: begin
                if (r_cnt == 4'd0) begin
                    w_state_nxt = S_REDIRECT;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            S_REDIRECT: begin
                if (redirect_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state    <= S_IDLE;
            r_cnt      <= 4'd0;
            r_int_take <= 1'b0;
            r_int_epc  <= 32'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_int_take <= w_int_take_nxt;
            r_int_epc  <= w_int_epc_nxt;
        end
    end

    // Target is only observed while in REDIRECT, so it needs no reset.
    always_ff @(posedge clk) begin
        r_tgt <= w_tgt_nxt;
    end

    assign flush          = (r_state == S_FLUSH);
    assign stall_fetch    = (r_state != S_IDLE);
    assign redirect_valid = (r_state == S_REDIRECT);
    assign redirect_pc    = (r_state == S_REDIRECT) ? r_tgt : 32'd0;
    assign int_take       = r_int_take;
    assign int_epc        = r_int_epc;
    assign busy           = (r_state != S_IDLE);

endmodule

// File: tb/tb_pipe_flush_ctrl.sv
// Directed bench for pipe_flush_ctrl (FLUSH_CYCLES=2, EXC_VECTOR=BFC00380).
module tb_pipe_flush_ctrl;

    logic        clk;
    logic        resetn;
    logic        exception_valid;
    logic [31:0] exc_target;
    logic        eret;
    logic [31:0] eret_target;
    logic        mtc0;
    logic [31:0] mtc0_next_pc;
    logic        int_pending;
    logic        commit_valid;
    logic [31:0] commit_pc;
    logic        redirect_ready;
    logic        flush;
    logic        stall_fetch;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        int_take;
    logic [31:0] int_epc;
    logic        busy;

    int n_vec;
    int n_err;

    pipe_flush_ctrl #(
        .FLUSH_CYCLES(2),
        .EXC_VECTOR  (32'hBFC00380)
    ) dut (
        .clk            (clk),
        .resetn         (resetn),
        .exception_valid(exception_valid),
        .exc_target     (exc_target),
        .eret           (eret),
        .eret_target    (eret_target),
        .mtc0           (mtc0),
        .mtc0_next_pc   (mtc0_next_pc),
        .int_pending    (int_pending),
        .commit_valid   (commit_valid),
        .commit_pc      (commit_pc),
        .redirect_ready (redirect_ready),
        .flush          (flush),
        .stall_fetch    (stall_fetch),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .int_take       (int_take),
        .int_epc        (int_epc),
        .busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {flush, stall_fetch, redirect_valid, int_take, busy}
    function automatic logic [4:0] ctl();
        return {flush, stall_fetch, redirect_valid, int_take, busy};
    endfunction

    task automatic step();
        @(negedge clk);
    endtask

    task automatic clear_events();
        exception_valid = 1'b0;
        eret            = 1'b0;
        mtc0            = 1'b0;
        int_pending     = 1'b0;
        commit_valid    = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        clear_events();
        exc_target = 32'h0; eret_target = 32'h0; mtc0_next_pc = 32'h0;
        commit_pc = 32'h0; redirect_ready = 1'b0;
        step(); step(); step();
        n_vec++;
        if (ctl() !== 5'b00000) begin
            n_err++; $display("FAIL reset_ctl: got %b expected %b", ctl(), 5'b00000);
        end
        n_vec++;
        if (redirect_pc !== 32'h0 || int_epc !== 32'h0) begin
            n_err++; $display("FAIL reset_data: got pc %h epc %h expected 0 0", redirect_pc, int_epc);
        end
        resetn = 1'b1;
        step();
    endtask

    task automatic test_exception();
        exception_valid = 1'b1; exc_target = 32'hBFC00380; redirect_ready = 1'b1;
        step();
        clear_events();
        n_vec++;
        if (ctl() !== 5'b11001) begin
            n_err++; $display("FAIL exc_flush1: got %b expected %b", ctl(), 5'b11001);
        end
        step();
        n_vec++;
        if (ctl() !== 5'b11001) begin
            n_err++; $display("FAIL exc_flush2: got %b expected %b", ctl(), 5'b11001);
        end
        step();
        n_vec++;
        if (ctl() !== 5'b01101 || redirect_pc !== 32'hBFC00380) begin
            n_err++; $display("FAIL exc_redirect: got %b/%h expected %b/%h", ctl(), redirect_pc, 5'b01101, 32'hBFC00380);
        end
        step();
        n_vec++;
        if (ctl() !== 5'b00000 || redirect_pc !== 32'h0) begin
            n_err++; $display("FAIL exc_idle: got %b/%h expected %b/0", ctl(), redirect_pc, 5'b00000);
        end
    endtask

    task automatic test_eret_hold();
        redirect_ready = 1'b0;
        eret = 1'b1; eret_target = 32'h80001234;
        step();
        clear_events();
        step(); step();
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (ctl() !== 5'b01101 || redirect_pc !== 32'h80001234) begin
                n_err++; $display("FAIL eret_hold%0d: got %b/%h expected %b/%h", i, ctl(), redirect_pc, 5'b01101, 32'h80001234);
            end
            if (i == 3) redirect_ready = 1'b1;
            step();
        end
        n_vec++;
        if (busy !== 1'b0) begin
            n_err++; $display("FAIL eret_idle: got busy %b expected 0", busy);
        end
    endtask

    task automatic test_priority();
        redirect_ready = 1'b1;
        exception_valid = 1'b1; exc_target = 32'hBFC00380;
        mtc0 = 1'b1; mtc0_next_pc = 32'h80000010;
        step();
        clear_events();
        step(); step();
        n_vec++;
        if (redirect_pc !== 32'hBFC00380) begin
            n_err++; $display("FAIL prio_exc_mtc0: got %h expected %h", redirect_pc, 32'hBFC00380);
        end
        step();
        n_vec++;
        if (busy !== 1'b0) begin
            n_err++; $display("FAIL prio_mtc0_dropped: got busy %b expected 0", busy);
        end
        eret = 1'b1; eret_target = 32'h80002000;
        int_pending = 1'b1; commit_valid = 1'b1; commit_pc = 32'h80000500;
        mtc0 = 1'b1; mtc0_next_pc = 32'h80000010;
        step();
        clear_events();
        n_vec++;
        if (int_take !== 1'b0 || int_epc !== 32'h0) begin
            n_err++; $display("FAIL prio_eret_int: got take %b epc %h expected 0 0", int_take, int_epc);
        end
        step(); step();
        n_vec++;
        if (redirect_pc !== 32'h80002000) begin
            n_err++; $display("FAIL prio_eret_pc: got %h expected %h", redirect_pc, 32'h80002000);
        end
        step();
    endtask

    task automatic test_interrupt();
        redirect_ready = 1'b1;
        int_pending = 1'b1; commit_valid = 1'b0; commit_pc = 32'h80000040;
        for (int i = 0; i < 2; i++) begin
            step();
            n_vec++;
            if (ctl() !== 5'b00000) begin
                n_err++; $display("FAIL int_wait%0d: got %b expected %b", i, ctl(), 5'b00000);
            end
        end
        commit_valid = 1'b1;
        step();
        clear_events();
        n_vec++;
        if (ctl() !== 5'b11011 || int_epc !== 32'h80000040) begin
            n_err++; $display("FAIL int_take: got %b/%h expected %b/%h", ctl(), int_epc, 5'b11011, 32'h80000040);
        end
        step();
        n_vec++;
        if (int_take !== 1'b0) begin
            n_err++; $display("FAIL int_pulse_width: got %b expected 0", int_take);
        end
        step();
        n_vec++;
        if (ctl() !== 5'b01101 || redirect_pc !== 32'hBFC00380) begin
            n_err++; $display("FAIL int_redirect: got %b/%h expected %b/%h", ctl(), redirect_pc, 5'b01101, 32'hBFC00380);
        end
        step();
    endtask

    task automatic test_mtc0();
        redirect_ready = 1'b1;
        mtc0 = 1'b1; mtc0_next_pc = 32'h80000010;
        step();
        clear_events();
        step(); step();
        n_vec++;
        if (ctl() !== 5'b01101 || redirect_pc !== 32'h80000010) begin
            n_err++; $display("FAIL mtc0_redirect: got %b/%h expected %b/%h", ctl(), redirect_pc, 5'b01101, 32'h80000010);
        end
        step();
    endtask

    task automatic test_ignore_busy();
        redirect_ready = 1'b0;
        exception_valid = 1'b1; exc_target = 32'hBFC00380;
        step();
        exc_target = 32'h11111110;
        step();
        step();
        n_vec++;
        if (redirect_pc !== 32'hBFC00380) begin
            n_err++; $display("FAIL ignore_r1: got %h expected %h", redirect_pc, 32'hBFC00380);
        end
        step();
        n_vec++;
        if (ctl() !== 5'b01101 || redirect_pc !== 32'hBFC00380) begin
            n_err++; $display("FAIL ignore_r2: got %b/%h expected %b/%h", ctl(), redirect_pc, 5'b01101, 32'hBFC00380);
        end
        redirect_ready = 1'b1;
        clear_events();
        step();
        step();
        n_vec++;
        if (ctl() !== 5'b00000) begin
            n_err++; $display("FAIL ignore_single: got %b expected %b", ctl(), 5'b00000);
        end
    endtask

    task automatic test_reset_mid();
        redirect_ready = 1'b1;
        exception_valid = 1'b1; exc_target = 32'hBFC00380;
        step();
        clear_events();
        n_vec++;
        if (flush !== 1'b1) begin
            n_err++; $display("FAIL rstmid_flush: got %b expected 1", flush);
        end
        resetn = 1'b0;
        step();
        n_vec++;
        if (ctl() !== 5'b00000 || redirect_pc !== 32'h0) begin
            n_err++; $display("FAIL rstmid_clear: got %b/%h expected %b/0", ctl(), redirect_pc, 5'b00000);
        end
        resetn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            n_vec++;
            if (redirect_valid !== 1'b0 || busy !== 1'b0) begin
                n_err++; $display("FAIL rstmid_noredir%0d: got rv %b busy %b expected 0 0", i, redirect_valid, busy);
            end
        end
    endtask

    task automatic test_back_to_back();
        redirect_ready = 1'b1;
        exception_valid = 1'b1; exc_target = 32'h80000100;
        step();
        clear_events();
        step(); step();
        n_vec++;
        if (redirect_pc !== 32'h80000100) begin
            n_err++; $display("FAIL b2b_first: got %h expected %h", redirect_pc, 32'h80000100);
        end
        step();
        eret = 1'b1; eret_target = 32'h80000200;
        n_vec++;
        if (busy !== 1'b0) begin
            n_err++; $display("FAIL b2b_idle: got busy %b expected 0", busy);
        end
        step();
        clear_events();
        n_vec++;
        if (ctl() !== 5'b11001) begin
            n_err++; $display("FAIL b2b_second_flush: got %b expected %b", ctl(), 5'b11001);
        end
        step(); step();
        n_vec++;
        if (redirect_pc !== 32'h80000200) begin
            n_err++; $display("FAIL b2b_second_pc: got %h expected %h", redirect_pc, 32'h80000200);
        end
        step();
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_exception();
        test_eret_hold();
        test_priority();
        test_interrupt();
        test_mtc0();
        test_ignore_busy();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
